// File: rtl/adder_tree_pipe.sv
// Pipelined binary adder tree with optional packet accumulation and saturation.
// One register per tree level plus an output stage; the whole pipe stalls together.
module adder_tree_pipe #(
    parameter int unsigned BITS     = 16,
    parameter int unsigned NUM      = 4,
    parameter bit          SIGNED   = 1'b1,
    parameter bit          SATURATE = 1'b0,
    parameter bit          ACCUM    = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                valid,
    output logic                ready,
    input  logic                last,
    input  logic [NUM*BITS-1:0] i,
    output logic [BITS-1:0]     o,
    output logic                valid_out,
    input  logic                ready_out,
    output logic                ovf
);

    localparam int unsigned LOG = $clog2(NUM);
    localparam int unsigned SW  = BITS + LOG;
    localparam int unsigned AW  = SW + 8;

    logic adv;
    assign adv   = !(valid_out && !ready_out);
    assign ready = adv;

    function automatic logic [SW-1:0] ext_op(input logic [BITS-1:0] x);
        ext_op = SIGNED ? {{LOG{x[BITS-1]}}, x} : {{LOG{1'b0}}, x};
    endfunction

    // Heap layout: node n sums children 2n and 2n+1; indices >= NUM are the operands.
    logic [NUM-1:1][SW-1:0]     node_q;
    logic [2*NUM-1:2][SW-1:0]   tree;
    logic [LOG-1:0]             vld_q;
    logic [LOG-1:0]             lst_q;

    always_comb begin
        tree = '0;
        for (int n = 2; n < NUM; n++) begin
            tree[n] = node_q[n];
        end
        for (int k = 0; k < NUM; k++) begin
            tree[NUM+k] = ext_op(i[k*BITS +: BITS]);
        end
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            for (int n = 1; n < NUM; n++) begin
                node_q[n] <= tree[2*n] + tree[2*n+1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= '0;
            lst_q <= '0;
        end else if (adv) begin
            vld_q <= (vld_q << 1) | LOG'(valid);
            lst_q <= (lst_q << 1) | LOG'(valid && last);
        end
    end

    logic            tree_vld;
    logic            tree_lst;
    logic            emit;
    logic            in_pkt_q;
    logic            oor;
    logic [AW-1:0]   sum_ext;
    logic [AW-1:0]   acc_q;
    logic [AW-1:0]   full;
    logic [AW-1:0]   res;
    logic [BITS-1:0] sat_val;
    logic [BITS-1:0] o_d;

    always_comb begin
        tree_vld = vld_q[LOG-1];
        tree_lst = lst_q[LOG-1];
        emit     = tree_vld && (!ACCUM || tree_lst);
        sum_ext  = SIGNED ? {{8{node_q[1][SW-1]}}, node_q[1]} : {8'b0, node_q[1]};
        full     = in_pkt_q ? acc_q + sum_ext : sum_ext;
        res      = ACCUM ? full : sum_ext;
        // Out of range when the bits above the result width are not a pure extension.
        if (SIGNED) begin
            oor = !((&res[AW-1:BITS-1]) || !(|res[AW-1:BITS-1]));
        end else begin
            oor = |res[AW-1:BITS];
        end
        sat_val = SIGNED ? (res[AW-1] ? {1'b1, {(BITS-1){1'b0}}} : {1'b0, {(BITS-1){1'b1}}})
                         : {BITS{1'b1}};
        o_d     = (SATURATE && oor) ? sat_val : res[BITS-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_out <= 1'b0;
            o         <= '0;
            ovf       <= 1'b0;
            acc_q     <= '0;
            in_pkt_q  <= 1'b0;
        end else if (adv) begin
            valid_out <= emit;
            if (emit) begin
                o   <= o_d;
                ovf <= oor;
            end
            if (ACCUM && tree_vld) begin
                acc_q    <= tree_lst ? '0 : full;
                in_pkt_q <= !tree_lst;
            end
        end
    end

endmodule

// File: tb/tb_adder_tree_pipe.sv
// Directed and randomized checks of adder_tree_pipe across several parameterizations.
module tb_adder_tree_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic        a_valid, a_last, a_ready_out, a_ready, a_vo, a_ovf;
    logic [63:0] a_i;
    logic [15:0] a_o;
    logic        s_ready, s_vo, s_ovf;
    logic [15:0] s_o;

    logic        c_valid, c_last, c_ready_out, c_ready, c_vo, c_ovf;
    logic [63:0] c_i;
    logic [15:0] c_o;

    logic         w_valid, w_last, w_ready_out, w_ready, w_vo, w_ovf;
    logic [127:0] w_i;
    logic [7:0]   w_o;
    logic         ws_ready, ws_vo, ws_ovf;
    logic [7:0]   ws_o;

    adder_tree_pipe u_a (
        .clk(clk), .reset(reset), .valid(a_valid), .ready(a_ready), .last(a_last), .i(a_i),
        .o(a_o), .valid_out(a_vo), .ready_out(a_ready_out), .ovf(a_ovf)
    );

    adder_tree_pipe #(.SATURATE(1'b1)) u_s (
        .clk(clk), .reset(reset), .valid(a_valid), .ready(s_ready), .last(a_last), .i(a_i),
        .o(s_o), .valid_out(s_vo), .ready_out(a_ready_out), .ovf(s_ovf)
    );

    adder_tree_pipe #(.ACCUM(1'b1)) u_c (
        .clk(clk), .reset(reset), .valid(c_valid), .ready(c_ready), .last(c_last), .i(c_i),
        .o(c_o), .valid_out(c_vo), .ready_out(c_ready_out), .ovf(c_ovf)
    );

    adder_tree_pipe #(.BITS(8), .NUM(16), .SIGNED(1'b0)) u_w (
        .clk(clk), .reset(reset), .valid(w_valid), .ready(w_ready), .last(w_last), .i(w_i),
        .o(w_o), .valid_out(w_vo), .ready_out(w_ready_out), .ovf(w_ovf)
    );

    adder_tree_pipe #(.BITS(8), .NUM(16), .SIGNED(1'b0), .SATURATE(1'b1)) u_ws (
        .clk(clk), .reset(reset), .valid(w_valid), .ready(ws_ready), .last(w_last), .i(w_i),
        .o(ws_o), .valid_out(ws_vo), .ready_out(w_ready_out), .ovf(ws_ovf)
    );

    int          checks = 0;
    int          errors = 0;
    int          c_pulses;
    logic [15:0] c_last_o;
    logic        c_last_ovf;
    longint      q[$];
    longint      full;
    int          sent, got, stalls, lim;
    logic [15:0] held_o;
    logic [63:0] bx, by, bz;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample just after the edge; tallies accumulator results.
    task automatic tick();
        @(posedge clk);
        #1;
        if (c_vo === 1'b1) begin
            c_pulses++;
            c_last_o   = c_o;
            c_last_ovf = c_ovf;
        end
    endtask

    function automatic longint opval(input logic [31:0] raw, input int bits, input bit sgn);
        longint m = (longint'(1) << bits) - 1;
        longint v = longint'(raw) & m;
        if (sgn && v[bits-1]) v = v - (m + 1);
        return v;
    endfunction

    function automatic longint tree_sum(input logic [255:0] vec, input int num, input int bits,
                                        input bit sgn);
        longint s = 0;
        for (int k = 0; k < num; k++) s += opval(32'(vec >> (k * bits)), bits, sgn);
        return s;
    endfunction

    function automatic bit ref_ovf(input longint v, input int bits, input bit sgn);
        longint lo = sgn ? -(longint'(1) << (bits - 1)) : 64'sd0;
        longint hi = sgn ? (longint'(1) << (bits - 1)) - 1 : (longint'(1) << bits) - 1;
        return (v < lo) || (v > hi);
    endfunction

    function automatic logic [31:0] ref_o(input longint v, input int bits, input bit sgn,
                                          input bit sat);
        longint lo = sgn ? -(longint'(1) << (bits - 1)) : 64'sd0;
        longint hi = sgn ? (longint'(1) << (bits - 1)) - 1 : (longint'(1) << bits) - 1;
        longint r  = v;
        if (sat && v < lo) r = lo;
        else if (sat && v > hi) r = hi;
        return 32'(r & ((longint'(1) << bits) - 1));
    endfunction

    function automatic logic [63:0] pack4(input logic [15:0] a, input logic [15:0] b,
                                          input logic [15:0] c, input logic [15:0] d);
        return {d, c, b, a};
    endfunction

    initial begin
        reset = 1'b1;
        a_valid = 1'b0; a_last = 1'b0; a_ready_out = 1'b1; a_i = '0;
        c_valid = 1'b0; c_last = 1'b0; c_ready_out = 1'b1; c_i = '0;
        w_valid = 1'b0; w_last = 1'b0; w_ready_out = 1'b1; w_i = '0;
        c_pulses = 0; c_last_o = '0; c_last_ovf = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        chk("rst_vo", a_vo, 0);
        chk("rst_o", a_o, 0);
        chk("rst_ovf", a_ovf, 0);
        chk("rst_c_vo", c_vo, 0);
        chk("rst_w_vo", w_vo, 0);
        #1;
        chk("rst_ready", a_ready, 1);

        // Single beat latency.
        a_i = pack4(16'd1, 16'd2, 16'd3, 16'd4);
        a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        chk("lat_e1", a_vo, 0);
        tick();
        chk("lat_e2", a_vo, 0);
        tick();
        chk("lat_vo", a_vo, 1);
        chk("lat_o", a_o, 16'h000A);
        chk("lat_ovf", a_ovf, 0);
        tick();
        chk("lat_drop", a_vo, 0);

        // Signed overflow, wrap vs saturate.
        bx = pack4(16'h7000, 16'h7000, 16'h7000, 16'h7000);
        by = pack4(16'hFFFF, 16'hFFFE, 16'h0003, 16'h0000);
        bz = pack4(16'h9000, 16'h9000, 16'h9000, 16'h9000);
        a_valid = 1'b1;
        a_i = bx; tick();
        a_i = by; tick();
        a_i = bz; tick();
        a_valid = 1'b0;
        chk("wrap_vo", a_vo, 1);
        chk("wrap_o", a_o, 16'hC000);
        chk("wrap_ovf", a_ovf, 1);
        chk("sat_o", s_o, 16'h7FFF);
        chk("sat_ovf", s_ovf, 1);
        tick();
        chk("zero_o", a_o, 16'h0000);
        chk("zero_ovf", a_ovf, 0);
        chk("zero_sat_o", s_o, 16'h0000);
        tick();
        full = tree_sum(256'(bz), 4, 16, 1'b1);
        chk("neg_wrap_o", a_o, ref_o(full, 16, 1'b1, 1'b0));
        chk("neg_sat_o", s_o, ref_o(full, 16, 1'b1, 1'b1));
        chk("neg_ovf", s_ovf, ref_ovf(full, 16, 1'b1));
        tick();
        tick();

        // Back-to-back stream with five stalled cycles mid-stream.
        q.delete(); sent = 0; got = 0; stalls = 0;
        for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
            a_ready_out = !(cyc >= 5 && cyc < 10);
            a_valid = (sent < 8);
            a_i = {$urandom, $urandom};
            #1;
            chk("bp_ready", a_ready, !(cyc >= 5 && cyc < 10));
            if (cyc == 5) held_o = a_o;
            if (cyc > 5 && cyc < 10) begin
                chk("bp_held_vo", a_vo, 1);
                chk("bp_held_o", a_o, held_o);
            end
            if (a_vo && !a_ready_out) stalls++;
            if (a_valid && a_ready) begin
                q.push_back(tree_sum(256'(a_i), 4, 16, 1'b1));
                sent++;
            end
            if (a_vo && a_ready_out) begin
                chk("bp_pending", q.size() > 0, 1);
                if (q.size() > 0) begin
                    full = q.pop_front();
                    chk("bp_o", a_o, ref_o(full, 16, 1'b1, 1'b0));
                    chk("bp_ovf", a_ovf, ref_ovf(full, 16, 1'b1));
                    chk("bp_sat_o", s_o, ref_o(full, 16, 1'b1, 1'b1));
                    got++;
                end
            end
            tick();
        end
        a_valid = 1'b0;
        a_ready_out = 1'b1;
        chk("bp_count", got, 8);
        chk("bp_stalls", stalls, 5);

        // Accumulated packet of three beats, then a single-beat packet.
        c_pulses = 0;
        c_valid = 1'b1;
        c_i = pack4(16'd1, 16'd1, 16'd1, 16'd1); tick();
        c_i = pack4(16'd2, 16'd2, 16'd2, 16'd2); tick();
        c_i = pack4(16'd3, 16'd3, 16'd3, 16'd3); c_last = 1'b1; tick();
        c_valid = 1'b0; c_last = 1'b0;
        repeat (6) tick();
        chk("acc_pulses", c_pulses, 1);
        chk("acc_o", c_last_o, 16'h0018);
        chk("acc_ovf", c_last_ovf, 0);
        c_pulses = 0;
        c_i = pack4(16'd1, 16'd2, 16'd3, 16'd4); c_last = 1'b1; c_valid = 1'b1;
        tick();
        c_valid = 1'b0; c_last = 1'b0;
        repeat (5) tick();
        chk("acc_single_pulses", c_pulses, 1);
        chk("acc_single_o", c_last_o, 16'h000A);

        // Reset with a nonzero accumulator and two beats in flight.
        c_pulses = 0;
        c_i = pack4(16'd7, 16'd7, 16'd7, 16'd7); c_valid = 1'b1;
        tick();
        c_valid = 1'b0;
        repeat (3) tick();
        c_valid = 1'b1;
        c_i = pack4(16'd9, 16'd9, 16'd9, 16'd9); tick();
        c_i = pack4(16'd11, 16'd11, 16'd11, 16'd11); tick();
        c_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_mid_vo", c_vo, 0);
        chk("rst_mid_o", c_o, 0);
        chk("rst_mid_ovf", c_ovf, 0);
        c_i = pack4(16'd5, 16'd5, 16'd5, 16'd5); c_last = 1'b1; c_valid = 1'b1;
        tick();
        c_valid = 1'b0; c_last = 1'b0;
        repeat (6) tick();
        chk("rst_pkt_pulses", c_pulses, 1);
        chk("rst_pkt_o", c_last_o, 16'h0014);

        // Randomized unsigned 16x8 stream with random backpressure.
        q.delete(); sent = 0; got = 0;
        for (int cyc = 0; cyc < 4000 && got < 500; cyc++) begin
            w_ready_out = ($urandom_range(0, 3) != 0);
            w_valid = (sent < 500) && ($urandom_range(0, 4) != 0);
            case ($urandom_range(0, 2))
                0:       lim = 15;
                1:       lim = 31;
                default: lim = 255;
            endcase
            for (int k = 0; k < 16; k++) w_i[k*8 +: 8] = 8'($urandom_range(0, lim));
            #1;
            if (w_valid && w_ready) begin
                q.push_back(tree_sum(256'(w_i), 16, 8, 1'b0));
                sent++;
            end
            if (w_vo && w_ready_out) begin
                chk("rnd_pending", q.size() > 0, 1);
                if (q.size() > 0) begin
                    full = q.pop_front();
                    chk("rnd_o", w_o, ref_o(full, 8, 1'b0, 1'b0));
                    chk("rnd_ovf", w_ovf, ref_ovf(full, 8, 1'b0));
                    chk("rnd_sat_o", ws_o, ref_o(full, 8, 1'b0, 1'b1));
                    chk("rnd_sat_ovf", ws_ovf, ref_ovf(full, 8, 1'b0));
                    got++;
                end
            end
            tick();
        end
        w_valid = 1'b0;
        chk("rnd_count", got, 500);
        chk("rnd_drain", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
